// File: rtl/unidade_mult_div.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO registers.
// One shift-add or restoring step per clock; MTHI/MTLO write HI/LO directly when idle.
module unidade_mult_div (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] dado_1,
  input  logic [31:0] dado_2,
  input  logic [2:0]  operacao,
  input  logic        inicio,
  output logic        ocupado,
  output logic        pronto,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {OCIOSO, CALCULA, AJUSTE} estado_t;

  estado_t     estado, prox_estado;
  logic [4:0]  contador;
  logic        eh_div;
  logic        neg_q, neg_r;
  logic        divisor_zero;
  logic [31:0] operando;
  logic [31:0] dado_1_orig;
  logic [63:0] acc;

  logic        aceita;
  logic        com_sinal;
  logic [32:0] soma;
  logic [63:0] mult_prox;
  logic [33:0] diferenca;
  logic        bit_q;
  logic [31:0] novo_resto;
  logic [63:0] div_prox;

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [31:0] magnitude(input logic signed [31:0] v, input logic sinal);
    logic signed [31:0] neg;
    neg = -v;
    return (sinal && v[31]) ? neg : v;
  endfunction

  function automatic logic [31:0] ajusta32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] ajusta64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  assign com_sinal = (operacao == OP_MULT) || (operacao == OP_DIV);
  assign aceita    = (estado == OCIOSO) && inicio &&
                     ((operacao == OP_MULT) || (operacao == OP_MULTU) ||
                      (operacao == OP_DIV)  || (operacao == OP_DIVU));

  // Multiply: multiplier sits in acc[31:0] and shifts out as the product shifts in.
  // Divide: acc holds {remainder, dividend/quotient} for a restoring step.
  always_comb begin
    soma       = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operando} : 33'd0);
    mult_prox  = {soma, acc[31:1]};
    diferenca  = {1'b0, acc[63:31]} - {2'b00, operando};
    bit_q      = ~diferenca[33];
    novo_resto = bit_q ? diferenca[31:0] : acc[62:31];
    div_prox   = {novo_resto, acc[30:0], bit_q};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) estado <= OCIOSO;
    else          estado <= prox_estado;
  end

  always_comb begin
    prox_estado = estado;
    case (estado)
      OCIOSO:  if (aceita) prox_estado = CALCULA;
      CALCULA: if (contador == 5'd31) prox_estado = AJUSTE;
      AJUSTE:  prox_estado = OCIOSO;
      default: prox_estado = OCIOSO;
    endcase
  end

  always_comb begin
    ocupado = (estado != OCIOSO);
  end

  // Operand / accumulator path: no reset, only meaningful while an op is in flight.
  always_ff @(posedge clock) begin
    if (aceita) begin
      eh_div       <= (operacao == OP_DIV) || (operacao == OP_DIVU);
      dado_1_orig  <= dado_1;
      divisor_zero <= (dado_2 == 32'd0);
      neg_q        <= com_sinal && (dado_1[31] ^ dado_2[31]);
      neg_r        <= com_sinal && dado_1[31];
      if ((operacao == OP_DIV) || (operacao == OP_DIVU)) begin
        operando <= magnitude(dado_2, com_sinal);
        acc      <= {32'd0, magnitude(dado_1, com_sinal)};
      end else begin
        operando <= magnitude(dado_1, com_sinal);
        acc      <= {32'd0, magnitude(dado_2, com_sinal)};
      end
    end else if (estado == CALCULA) begin
      acc <= eh_div ? div_prox : mult_prox;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hi       <= 32'd0;
      lo       <= 32'd0;
      pronto   <= 1'b0;
      div_zero <= 1'b0;
      contador <= 5'd0;
    end else begin
      pronto <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (aceita) begin
            div_zero <= 1'b0;
            contador <= 5'd0;
          end else if (inicio && (operacao == OP_MTHI)) begin
            hi <= dado_1;
          end else if (inicio && (operacao == OP_MTLO)) begin
            lo <= dado_1;
          end
        end
        CALCULA: contador <= contador + 5'd1;
        AJUSTE: begin
          pronto <= 1'b1;
          if (eh_div && divisor_zero) begin
            hi       <= dado_1_orig;
            lo       <= 32'hFFFF_FFFF;
            div_zero <= 1'b1;
          end else if (eh_div) begin
            lo <= ajusta32(acc[31:0], neg_q);
            hi <= ajusta32(acc[63:32], neg_r);
          end else begin
            {hi, lo} <= ajusta64(acc, neg_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_mult_div.sv
// Directed bench for unidade_mult_div: multiply/divide results, timing, MTHI/MTLO, overlap and reset.
module tb_unidade_mult_div;

  logic        clock;
  logic        reset_n;
  logic [31:0] dado_1, dado_2;
  logic [2:0]  operacao;
  logic        inicio;
  logic        ocupado, pronto, div_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  unidade_mult_div dut (
    .clock(clock), .reset_n(reset_n), .dado_1(dado_1), .dado_2(dado_2),
    .operacao(operacao), .inicio(inicio), .ocupado(ocupado), .pronto(pronto),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issues one request, then waits (bounded) for the unit to go idle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int ciclos, output logic dz_aceite, output logic p1, output logic p2);
    @(negedge clock);
    dado_1 = a; dado_2 = b; operacao = op; inicio = 1'b1;
    @(negedge clock);
    inicio = 1'b0; operacao = 3'b000; dado_1 = 32'hDEADBEEF; dado_2 = 32'hDEADBEEF;
    dz_aceite = div_zero;
    ciclos = 0;
    while (ocupado === 1'b1 && ciclos < 100) begin
      ciclos++;
      @(negedge clock);
    end
    p1 = pronto;
    @(negedge clock);
    p2 = pronto;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; inicio = 1'b0; operacao = 3'b000; dado_1 = 32'd0; dado_2 = 32'd0;
    repeat (3) @(negedge clock);
    total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL reset_ocupado got=%b exp=0", ocupado); end
    total++; if (pronto !== 1'b0) begin bad++; $display("FAIL reset_pronto got=%b exp=0", pronto); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_div_zero got=%b exp=0", div_zero); end
    total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL reset_hilo got=%h_%h exp=0_0", hi, lo); end
    reset_n = 1'b1;
  endtask

  task automatic test_mult;
    int c; logic dz, p1, p2;
    run_op(OP_MULT, 32'd7, 32'hFFFFFFFD, c, dz, p1, p2);
    total++; if (c !== 33) begin bad++; $display("FAIL mult_ocupado_ciclos got=%0d exp=33", c); end
    total++; if (p1 !== 1'b1) begin bad++; $display("FAIL mult_pronto_alto got=%b exp=1", p1); end
    total++; if (p2 !== 1'b0) begin bad++; $display("FAIL mult_pronto_um_ciclo got=%b exp=0", p2); end
    total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
    total++; if (lo !== 32'hFFFFFFEB) begin bad++; $display("FAIL mult_lo got=%h exp=ffffffeb", lo); end
  endtask

  task automatic test_mult_limites;
    int c; logic dz, p1, p2;
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, c, dz, p1, p2);
    total++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin bad++; $display("FAIL multu_max got=%h_%h exp=fffffffe_00000001", hi, lo); end
    run_op(OP_MULT, 32'h80000000, 32'h80000000, c, dz, p1, p2);
    total++; if ({hi, lo} !== 64'h40000000_00000000) begin bad++; $display("FAIL mult_min got=%h_%h exp=40000000_00000000", hi, lo); end
    run_op(OP_MULT, 32'hFFFFFFFF, 32'h00000005, c, dz, p1, p2);
    total++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFB) begin bad++; $display("FAIL mult_neg1x5 got=%h_%h exp=ffffffff_fffffffb", hi, lo); end
  endtask

  task automatic test_div;
    int c; logic dz, p1, p2;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, c, dz, p1, p2);
    total++; if (c !== 33) begin bad++; $display("FAIL div_ocupado_ciclos got=%0d exp=33", c); end
    total++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin bad++; $display("FAIL div_m7_2 got=%h_%h exp=ffffffff_fffffffd", hi, lo); end
    run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, c, dz, p1, p2);
    total++; if ({hi, lo} !== 64'h00000001_FFFFFFFD) begin bad++; $display("FAIL div_7_m2 got=%h_%h exp=00000001_fffffffd", hi, lo); end
    run_op(OP_DIVU, 32'd7, 32'd2, c, dz, p1, p2);
    total++; if ({hi, lo} !== 64'h00000001_00000003) begin bad++; $display("FAIL divu_7_2 got=%h_%h exp=00000001_00000003", hi, lo); end
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, c, dz, p1, p2);
    total++; if ({hi, lo} !== 64'h00000000_80000000) begin bad++; $display("FAIL div_min_m1 got=%h_%h exp=00000000_80000000", hi, lo); end
    run_op(OP_DIVU, 32'hFFFFFFFF, 32'h00010000, c, dz, p1, p2);
    total++; if ({hi, lo} !== 64'h0000FFFF_0000FFFF) begin bad++; $display("FAIL divu_big got=%h_%h exp=0000ffff_0000ffff", hi, lo); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL div_sem_zero got=%b exp=0", div_zero); end
  endtask

  task automatic test_div_zero;
    int c; logic dz, p1, p2;
    run_op(OP_DIV, 32'h12345678, 32'd0, c, dz, p1, p2);
    total++; if (c !== 33) begin bad++; $display("FAIL divzero_ciclos got=%0d exp=33", c); end
    total++; if ({hi, lo} !== 64'h12345678_FFFFFFFF) begin bad++; $display("FAIL divzero_hilo got=%h_%h exp=12345678_ffffffff", hi, lo); end
    total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL divzero_flag got=%b exp=1", div_zero); end
    run_op(OP_DIV, 32'hFFFFFFFB, 32'd0, c, dz, p1, p2);
    total++; if ({hi, lo} !== 64'hFFFFFFFB_FFFFFFFF) begin bad++; $display("FAIL divzero_neg got=%h_%h exp=fffffffb_ffffffff", hi, lo); end
    run_op(OP_MULTU, 32'd2, 32'd3, c, dz, p1, p2);
    total++; if (dz !== 1'b0) begin bad++; $display("FAIL divzero_limpa_aceite got=%b exp=0", dz); end
    total++; if (lo !== 32'd6) begin bad++; $display("FAIL multu_2x3_lo got=%h exp=00000006", lo); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL multu_2x3_hi got=%h exp=00000000", hi); end
  endtask

  task automatic test_mthi_mtlo;
    @(negedge clock);
    dado_1 = 32'h55; operacao = OP_MTLO; inicio = 1'b1;
    @(negedge clock);
    inicio = 1'b0; operacao = 3'b000;
    total++; if (lo !== 32'h55) begin bad++; $display("FAIL mtlo got=%h exp=00000055", lo); end
    total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL mtlo_ocupado got=%b exp=0", ocupado); end
    dado_1 = 32'h11; operacao = OP_MTHI; inicio = 1'b1;
    @(negedge clock);
    dado_1 = 32'h22; operacao = OP_MTLO;
    @(negedge clock);
    inicio = 1'b0; operacao = 3'b000;
    total++; if ({hi, lo} !== 64'h00000011_00000022) begin bad++; $display("FAIL mt_seguidos got=%h_%h exp=00000011_00000022", hi, lo); end
    dado_1 = 32'h99; operacao = 3'b111; inicio = 1'b1;
    @(negedge clock);
    inicio = 1'b0; operacao = 3'b000;
    total++; if (ocupado !== 1'b0 || {hi, lo} !== 64'h00000011_00000022) begin
      bad++; $display("FAIL op111_ignorada got=%b/%h_%h exp=0/00000011_00000022", ocupado, hi, lo);
    end
  endtask

  task automatic test_overlap;
    int c;
    @(negedge clock);
    dado_1 = 32'd7; dado_2 = 32'hFFFFFFFD; operacao = OP_MULT; inicio = 1'b1;
    @(negedge clock);
    inicio = 1'b0; operacao = 3'b000;
    repeat (9) @(negedge clock);
    dado_1 = 32'hAAAA0000; operacao = OP_MTHI; inicio = 1'b1;
    @(negedge clock);
    inicio = 1'b0; operacao = 3'b000;
    c = 0;
    while (ocupado === 1'b1 && c < 100) begin c++; @(negedge clock); end
    total++; if (c >= 100) begin bad++; $display("FAIL overlap_timeout got=%0d exp<100", c); end
    total++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin bad++; $display("FAIL overlap_mthi_ignorado got=%h_%h exp=ffffffff_ffffffeb", hi, lo); end
  endtask

  task automatic test_reset_mid;
    int c;
    @(negedge clock);
    dado_1 = 32'd100; dado_2 = 32'd7; operacao = OP_DIV; inicio = 1'b1;
    @(negedge clock);
    inicio = 1'b0; operacao = 3'b000;
    repeat (14) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL rstmeio_ocupado got=%b exp=0", ocupado); end
    total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL rstmeio_hilo got=%h_%h exp=0_0", hi, lo); end
    total++; if (pronto !== 1'b0) begin bad++; $display("FAIL rstmeio_pronto got=%b exp=0", pronto); end
    reset_n = 1'b1; dado_1 = 32'd2; dado_2 = 32'd3; operacao = OP_MULTU; inicio = 1'b1;
    @(negedge clock);
    inicio = 1'b0; operacao = 3'b000;
    total++; if (ocupado !== 1'b1) begin bad++; $display("FAIL rstmeio_aceite got=%b exp=1", ocupado); end
    c = 0;
    while (ocupado === 1'b1 && c < 100) begin
      c++;
      total++; if (pronto !== 1'b0) begin bad++; $display("FAIL rstmeio_pronto_espurio got=%b exp=0", pronto); end
      @(negedge clock);
    end
    total++; if (c !== 33) begin bad++; $display("FAIL rstmeio_ciclos got=%0d exp=33", c); end
    total++; if ({hi, lo} !== 64'h00000000_00000006) begin bad++; $display("FAIL rstmeio_resultado got=%h_%h exp=00000000_00000006", hi, lo); end
  endtask

  task automatic test_back_to_back;
    int c;
    @(negedge clock);
    dado_1 = 32'd5; dado_2 = 32'd6; operacao = OP_MULTU; inicio = 1'b1;
    @(negedge clock);
    inicio = 1'b0; operacao = 3'b000;
    c = 0;
    while (ocupado === 1'b1 && c < 100) begin c++; @(negedge clock); end
    total++; if (pronto !== 1'b1) begin bad++; $display("FAIL b2b_pronto got=%b exp=1", pronto); end
    dado_1 = 32'd100; dado_2 = 32'd7; operacao = OP_DIVU; inicio = 1'b1;
    @(negedge clock);
    inicio = 1'b0; operacao = 3'b000;
    total++; if (ocupado !== 1'b1) begin bad++; $display("FAIL b2b_aceite got=%b exp=1", ocupado); end
    total++; if (lo !== 32'd30) begin bad++; $display("FAIL b2b_mult_lo got=%h exp=0000001e", lo); end
    c = 0;
    while (ocupado === 1'b1 && c < 100) begin c++; @(negedge clock); end
    total++; if ({hi, lo} !== 64'h00000002_0000000E) begin bad++; $display("FAIL b2b_divu got=%h_%h exp=00000002_0000000e", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_mult_limites();
    test_div();
    test_div_zero();
    test_mthi_mtlo();
    test_overlap();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unidade_mult_div.md
# unidade_mult_div

Iterative multiply/divide unit with HI/LO registers for the single-cycle MIPS datapath. It sits directly downstream of the register bank and consumes the bank's two read outputs (R[s], R[t]) for MULT, MULTU, DIV, DIVU, MTHI and MTLO. Results land in the architectural HI/LO registers, which MFHI/MFLO read. The unit raises `ocupado` so the control unit can stall the processor while an operation is in flight.

## Interface
Parameters:
- none; the datapath is fixed at 32 bits and HI/LO at 32 bits each.

Ports:
- `clock` in 1: single clock; all state updates on posedge.
- `reset_n` in 1: reset is synchronous and active-low, sampled on posedge `clock`.
- `dado_1` in 32: R[s] from the register bank (dividend / multiplicand / MTHI/MTLO source).
- `dado_2` in 32: R[t] from the register bank (divisor / multiplier).
- `operacao` in 3: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none.
- `inicio` in 1: request strobe, sampled on posedge.
- `ocupado` out 1: an operation is in flight; the processor must stall.
- `pronto` out 1: one-cycle pulse; HI/LO have just been updated by MULT/DIV.
- `div_zero` out 1: the last completed DIV/DIVU had divisor 0.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
States: OCIOSO, CALCULA, AJUSTE.

OCIOSO:
- `inicio`=1 with MULT/MULTU/DIV/DIVU: latch the operands and the op, clear `div_zero`, load counter=0, go to CALCULA.
- Signed ops convert operands to magnitudes at latch time and record the result sign(s).
- MTHI: `hi`<=`dado_1` on that edge; state stays OCIOSO and `ocupado` stays 0. MTLO does the same for `lo`.
- `operacao` 000/111: ignored.

CALCULA (exactly 32 edges, counter 0..31):
- Multiply: one shift-add step per edge over a 64-bit accumulator.
- Divide: one restoring step per edge, producing the 32-bit quotient and remainder.
- When counter=31, go to AJUSTE.

AJUSTE (one edge):
- Apply the sign correction, write `hi`/`lo`, set `pronto`=1 for the next cycle and return to OCIOSO.
- Multiply result: `hi`=product[63:32], `lo`=product[31:0].
- Divide result: `lo`=quotient, `hi`=remainder.

Arithmetic rules:
- Signed multiply: the 64-bit product is negated if the operand signs differ.
- Signed divide:
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000 and `hi`=0, with no trap.
- Magnitude of 0x80000000 is handled as unsigned 0x80000000.
- Divisor 0, signed or unsigned, still takes the full latency:
  - Result: `hi`=original `dado_1`, `lo`=0xFFFFFFFF.
  - `div_zero`=1 from the AJUSTE edge until the next accepted MULT/DIV.

Boundary conditions:
- `inicio` while `ocupado`=1: ignored entirely, including MTHI/MTLO.
- Operand inputs are don't-care after the accept edge.
- `reset_n`=0 at any edge, including mid-operation:
  - Aborts the operation with no HI/LO write and no `pronto`.
  - Next state is OCIOSO.

Reset values: `hi`=0, `lo`=0, `ocupado`=0, `pronto`=0, `div_zero`=0, counter=0.

## Timing
- Accept edge E0: `ocupado`=1 during the cycles after E0 through E33.
- E1..E32: iterations; E33: AJUSTE writes HI/LO.
- After E33: `ocupado`=0, `pronto`=1 for exactly one cycle, new `hi`/`lo` visible.
- Latency is 33 edges from accept to result; occupancy is 33 cycles.
- A new request is accepted at E34 at the earliest, i.e. during the `pronto` cycle.
- MTHI/MTLO: 1-edge latency, zero occupancy; back-to-back MTHI/MTLO on consecutive edges is allowed.
- `ocupado` and `pronto` are registered outputs with no combinational path from `inicio`.

## Test plan
- MULT with `dado_1`=7, `dado_2`=0xFFFFFFFD (-3) -> after E33: `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `pronto` high for one cycle; `ocupado` high for exactly 33 cycles.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001. MULT 0x80000000 x 0x80000000 -> `hi`=0x40000000, `lo`=0.
- DIV -7/2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 7/2 -> `lo`=3, `hi`=1. DIV 0x80000000/0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIV 0x12345678/0 -> `hi`=0x12345678, `lo`=0xFFFFFFFF, `div_zero`=1. A following MULTU 2x3 clears `div_zero` at its accept edge and yields `lo`=6.
- Overlap: MTHI with `dado_1`=0xAAAA0000 and `inicio` pulsed at E10 during a MULT accepted at E0 -> ignored; `hi` holds the MULT result. MTLO 0x55 while idle -> `lo`=0x55 after one edge.
- Reset mid-operation: `reset_n`=0 at E15 of a DIV -> `hi`=`lo`=0, `ocupado`=0, and no `pronto` pulse. With `reset_n`=1 at E16, a request with `inicio`=1 is accepted at E16.
